// File: rtl/roteador_pkg.sv
// Shared types and default sizes for the round-robin router.
package roteador_pkg;

  typedef enum logic {
    MODO_FIXO = 1'b0,
    MODO_RR   = 1'b1
  } modo_t;

  localparam int unsigned NCANAIS_PADRAO = 4;
  localparam int unsigned W_PADRAO       = 4;
  localparam int unsigned WCONT_PADRAO   = 8;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin arbiter: first requester after the pointer, wrapping.
module arbitro_rr #(
  parameter int unsigned NCANAIS = 4
) (
  input  logic [NCANAIS-1:0]         req_i,
  input  logic [$clog2(NCANAIS)-1:0] ptr_i,
  output logic [NCANAIS-1:0]         gnt_o,
  output logic [$clog2(NCANAIS)-1:0] idx_o,
  output logic                       any_o
);

  localparam int unsigned SW = $clog2(NCANAIS);

  // Scan ptr+1 .. ptr+NCANAIS (mod NCANAIS) and keep the first hit.
  always_comb begin
    int unsigned c;
    logic        achou;
    gnt_o = '0;
    idx_o = '0;
    achou = 1'b0;
    c     = 0;
    for (int unsigned k = 1; k <= NCANAIS; k++) begin
      c = (int'(ptr_i) + k) % NCANAIS;
      if (!achou && req_i[c]) begin
        achou    = 1'b1;
        idx_o    = SW'(c);
        gnt_o[c] = 1'b1;
      end
    end
    any_o = achou;
  end

endmodule

// File: rtl/roteador_rr.sv
// N-channel to 1 router with fixed or round-robin selection and a registered output.
module roteador_rr
  import roteador_pkg::*;
#(
  parameter int unsigned NCANAIS = NCANAIS_PADRAO,
  parameter int unsigned W       = W_PADRAO,
  parameter int unsigned WCONT   = WCONT_PADRAO
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       modo,
  input  logic [$clog2(NCANAIS)-1:0] sel,
  input  logic [NCANAIS*W-1:0]       entrada,
  input  logic [NCANAIS-1:0]         valido,
  output logic [NCANAIS-1:0]         pronto,
  output logic [W-1:0]               saida,
  output logic                       saida_valida,
  input  logic                       saida_pronta,
  output logic [$clog2(NCANAIS)-1:0] saida_canal,
  output logic [WCONT-1:0]           contagem
);

  localparam int unsigned SW = $clog2(NCANAIS);

  logic [W-1:0]       saida_q;
  logic               valida_q;
  logic [SW-1:0]      canal_q;
  logic [SW-1:0]      ptr_q;
  logic [WCONT-1:0]   cont_q;

  modo_t              modo_w;
  logic               livre;
  logic               sel_ok;
  logic [NCANAIS-1:0] arb_gnt;
  logic [SW-1:0]      arb_idx;
  logic               arb_any;
  logic [NCANAIS-1:0] gnt;
  logic [SW-1:0]      gnt_idx;
  logic               xfer;
  logic [W-1:0]       dado;

  assign modo_w = modo_t'(modo);
  assign livre  = !valida_q || saida_pronta;
  assign sel_ok = ({1'b0, sel} < (SW + 1)'(NCANAIS));

  arbitro_rr #(
    .NCANAIS(NCANAIS)
  ) u_arbitro (
    .req_i(valido),
    .ptr_i(ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx),
    .any_o(arb_any)
  );

  // Pick the granted channel for the current mode; reset blocks every grant.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (modo_w == MODO_RR) begin
      gnt     = arb_gnt;
      gnt_idx = arb_idx;
    end else if (sel_ok && valido[sel]) begin
      gnt[sel] = 1'b1;
      gnt_idx  = sel;
    end
    pronto = (livre && !reset) ? gnt : '0;
    xfer   = |(valido & pronto);
    dado   = entrada[int'(gnt_idx)*W +: W];
  end

  // Output register, pointer and transfer counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      saida_q  <= '0;
      valida_q <= 1'b0;
      canal_q  <= '0;
      ptr_q    <= SW'(NCANAIS - 1);
      cont_q   <= '0;
    end else if (xfer) begin
      saida_q  <= dado;
      valida_q <= 1'b1;
      canal_q  <= gnt_idx;
      ptr_q    <= gnt_idx;
      cont_q   <= cont_q + 1'b1;
    end else if (saida_pronta) begin
      valida_q <= 1'b0;
    end
  end

  assign saida        = saida_q;
  assign saida_valida = valida_q;
  assign saida_canal  = canal_q;
  assign contagem     = cont_q;

  // arb_any is implied by a nonzero arb_gnt; keep it observable for the grant path.
  logic unused_any;
  assign unused_any = arb_any;

endmodule

// File: tb/tb_roteador_rr.sv
// Directed test of roteador_rr; a second instance with WCONT=4 checks counter wrap.
module tb_roteador_rr;

  logic        clock = 1'b0;
  logic        reset;
  logic        modo;
  logic [1:0]  sel;
  logic [15:0] entrada;
  logic [3:0]  valido;
  logic        saida_pronta;

  logic [3:0]  pronto;
  logic [3:0]  saida;
  logic        saida_valida;
  logic [1:0]  saida_canal;
  logic [7:0]  contagem;

  logic [3:0]  pronto_c;
  logic [3:0]  saida_c;
  logic        saida_valida_c;
  logic [1:0]  saida_canal_c;
  logic [3:0]  contagem_c;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  roteador_rr dut (
    .clock(clock), .reset(reset), .modo(modo), .sel(sel), .entrada(entrada),
    .valido(valido), .pronto(pronto), .saida(saida), .saida_valida(saida_valida),
    .saida_pronta(saida_pronta), .saida_canal(saida_canal), .contagem(contagem)
  );

  roteador_rr #(.NCANAIS(4), .W(4), .WCONT(4)) dut_c (
    .clock(clock), .reset(reset), .modo(modo), .sel(sel), .entrada(entrada),
    .valido(valido), .pronto(pronto_c), .saida(saida_c), .saida_valida(saida_valida_c),
    .saida_pronta(saida_pronta), .saida_canal(saida_canal_c), .contagem(contagem_c)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input int d, input int c, input int v, input int n);
    chk({tag, ".saida"}, saida, d);
    chk({tag, ".canal"}, saida_canal, c);
    chk({tag, ".valida"}, saida_valida, v);
    chk({tag, ".contagem"}, contagem, n);
  endtask

  // Channel data: ch3=D, ch2=A, ch1=5, ch0=3.
  int exp_rr_d[5] = '{3, 5, 10, 13, 3};

  initial begin
    reset = 1'b1; modo = 1'b0; sel = 2'd0; entrada = 16'hDA53;
    valido = 4'b0000; saida_pronta = 1'b0;
    tick(); tick();
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.pronto", pronto, 0);

    // Fixed mode, channel 2.
    reset = 1'b0; modo = 1'b0; sel = 2'd2; valido = 4'b0100; saida_pronta = 1'b1;
    #1 chk("fixo.pronto", pronto, 4'b0100);
    tick();
    chk_out("fixo", 4'hA, 2, 1, 1);

    // No request with accept: valida drops, data/canal hold.
    valido = 4'b0000;
    #1 chk("idle.pronto", pronto, 0);
    tick();
    chk_out("idle", 4'hA, 2, 0, 1);

    // Fixed transfer from ch3 leaves the pointer at 3 for the RR sequence.
    sel = 2'd3; valido = 4'b1000;
    tick();
    chk_out("fixo3", 4'hD, 3, 1, 2);

    // RR with all channels requesting: 0,1,2,3,0 back to back.
    modo = 1'b1; valido = 4'b1111;
    #1 chk("rr.pronto0", pronto, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), exp_rr_d[i], i % 4, 1, 3 + i);
    end

    // RR with ch1/ch3; stall after the first word.
    valido = 4'b1010;
    #1 chk("stall.pronto_a", pronto, 4'b0010);
    tick();
    chk_out("stall.w1", 5, 1, 1, 8);
    saida_pronta = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("stall.pronto%0d", i), pronto, 0);
      tick();
      chk_out($sformatf("stall.hold%0d", i), 5, 1, 1, 8);
    end
    saida_pronta = 1'b1;
    #1 chk("stall.pronto_b", pronto, 4'b1000);
    tick();
    chk_out("stall.w2", 4'hD, 3, 1, 9);

    // Fixed sel=1 with ch1 idle: no grant, then switch to RR.
    modo = 1'b0; sel = 2'd1; valido = 4'b1101;
    #1 chk("sel1.pronto", pronto, 0);
    tick();
    chk_out("sel1", 4'hD, 3, 0, 9);
    modo = 1'b1;
    #1 chk("sw.pronto", pronto, 4'b0001);
    tick();
    chk_out("sw", 3, 0, 1, 10);

    // Seven more RR transfers: 17 in total, so the 4-bit counter reads 1.
    valido = 4'b1111;
    for (int i = 0; i < 7; i++) tick();
    chk_out("wrap", 4'hD, 3, 1, 17);
    chk("wrap.contagem_c", contagem_c, 1);

    // Reset while holding a word with every channel requesting.
    reset = 1'b1; saida_pronta = 1'b0;
    #1 chk("rst2.pronto_a", pronto, 0);
    tick();
    chk_out("rst2", 0, 0, 0, 0);
    chk("rst2.pronto_b", pronto, 0);
    chk("rst2.contagem_c", contagem_c, 0);
    reset = 1'b0; saida_pronta = 1'b1;
    #1 chk("rst2.pronto_c", pronto, 4'b0001);
    tick();
    chk_out("rst2.first", 3, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/roteador_rr.md
ROTEADOR_RR -- requirements
Module: roteador_rr

Interface
REQ-001 Parameter NCANAIS, default 4: number of input channels, 2..16.
REQ-002 Parameter W, default 4: data width in bits, 1..32.
REQ-003 Parameter WCONT, default 8: width of the transfer counter.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 modo  input  1  0 = fixed selection by sel (MODO_FIXO); 1 = round-robin arbitration (MODO_RR).
REQ-007 sel  input  $clog2(NCANAIS)  channel index used in MODO_FIXO.
REQ-008 entrada  input  NCANAIS*W  packed channel data; channel i occupies bits [i*W +: W].
REQ-009 valido  input  NCANAIS  per-channel data-valid.
REQ-010 pronto  output  NCANAIS  per-channel ready; combinational.
REQ-011 saida  output  W  registered routed data.
REQ-012 saida_valida  output  1  saida holds a word.
REQ-013 saida_pronta  input  1  downstream accepts saida this cycle.
REQ-014 saida_canal  output  $clog2(NCANAIS)  index of the channel that produced saida.
REQ-015 contagem  output  WCONT  total accepted transfers; wraps modulo 2^WCONT.

Function
REQ-016 The output register is free when saida_valida=0 or saida_pronta=1 ("livre").
REQ-017 Grant in MODO_FIXO: channel sel, only if sel<NCANAIS and valido[sel]=1.
REQ-018 Grant in MODO_RR: first i with valido[i]=1, searching from ponteiro+1 upward and wrapping modulo NCANAIS.
REQ-019 pronto[i] = livre AND (i is the granted channel); at most one bit of pronto is high per cycle.
REQ-020 Transfer from channel i occurs when valido[i] AND pronto[i].
REQ-021 On a transfer, next cycle: saida=entrada[i], saida_canal=i, saida_valida=1; latency is exactly 1 cycle.
REQ-022 On a transfer, ponteiro becomes i in both modes.
REQ-023 ponteiro is otherwise unchanged, including across changes of modo.
REQ-024 No transfer and saida_pronta=1: saida_valida becomes 0; saida and saida_canal hold their values.
REQ-025 No transfer and saida_pronta=0: all outputs hold.
REQ-026 A downstream accept and a new transfer in the same cycle give back-to-back words with no bubble, 1 word/cycle.
REQ-027 contagem increments by 1 per transfer and wraps from 2^WCONT-1 to 0.
REQ-028 No valid requests, or sel out of range: no grant and pronto=0.
REQ-029 modo and sel are sampled every cycle; a change takes effect on the same cycle's grant and never corrupts a word already held in saida.
REQ-030 Data on a channel whose valido=1 and pronto=0 is not consumed; the source holds it.

Reset
REQ-031 While reset=1 at a clock edge: saida=0, saida_valida=0, saida_canal=0, contagem=0, ponteiro=NCANAIS-1, so channel 0 has first RR priority.
REQ-032 While reset=1, pronto=0 and no transfer occurs; reset overrides a simultaneous transfer or accept.
REQ-033 A word pending in saida during reset is discarded.

Structure
REQ-034 Package roteador_pkg holds: typedef enum logic {MODO_FIXO, MODO_RR} modo_t; default constants NCANAIS_PADRAO=4, W_PADRAO=4, WCONT_PADRAO=8.
REQ-035 A combinational sub-module arbitro_rr (inputs: request vector, pointer; outputs: one-hot grant, grant index, any-grant) implements REQ-018.
REQ-036 Top-level state is limited to saida, saida_valida, saida_canal, ponteiro and contagem.

Verification
REQ-037 Reset, then MODO_FIXO, sel=2, entrada ch2=4'hA, valido=4'b0100, saida_pronta=1 -> pronto=4'b0100; next cycle saida=4'hA, saida_canal=2, saida_valida=1, contagem=1.
REQ-038 MODO_RR, valido=4'b1111 held, saida_pronta=1 -> saida_canal sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
REQ-039 MODO_RR, valido=4'b1010, saida_pronta=0 for 3 cycles after the first word -> saida holds the ch1 word, pronto=0; on saida_pronta=1 the next word comes from ch3.
REQ-040 MODO_FIXO, sel=1, valido=4'b1101 -> pronto=0 and saida_valida drops to 0 after accept; switch to MODO_RR -> grant goes to the next valid channel after ponteiro.
REQ-041 WCONT=4, 17 transfers -> contagem=1 (wrap verified).
REQ-042 reset=1 asserted while saida_valida=1 and valido=4'b1111 -> next cycle all outputs 0 and pronto=0; first grant after release goes to ch0 in MODO_RR.
